// File: rtl/ast_pkt_gen.sv
// Avalon-ST packet generator: on start, emits one packet of pkt_len bytes whose
// byte k carries k mod 256 (first byte on the wire in the MSB lane), tagged with pkt_chan.
module ast_pkt_gen #(
    parameter int DATA_W    = 64,
    parameter int EMPTY_W   = 3,
    parameter int CHANNEL_W = 8,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     pkt_len,
    input  logic [CHANNEL_W-1:0] pkt_chan,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          pkt_cnt,
    output logic [DATA_W-1:0]    src_data,
    output logic                 src_sop,
    output logic                 src_eop,
    output logic                 src_val,
    output logic [EMPTY_W-1:0]   src_empty,
    output logic                 src_error,
    output logic [CHANNEL_W-1:0] src_channel,
    output logic                 src_tuser,
    input  logic                 src_ready,
    output logic                 dbg_state
);

    localparam int             B    = DATA_W / 8;
    localparam int             AW   = LEN_W + 1;
    localparam logic [AW-1:0]  B_AW = AW'(B);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // Handshake: a beat moves on a clock edge where src_val && src_ready; while
    // src_val is high and src_ready low every src_* output holds its value.

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [CHANNEL_W-1:0]   chan_q, chan_d;
    logic [AW-1:0]          word_q, word_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [EMPTY_W-1:0]     empty_q, empty_d;
    logic [CHANNEL_W-1:0]   chan_out_q, chan_out_d;

    logic                   show;
    logic                   last;
    logic [AW-1:0]          base;
    logic [AW-1:0]          pos;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        chan_d  = chan_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (pkt_len != '0)) begin
                    state_d = SEND;
                    len_d   = pkt_len;
                    chan_d  = pkt_chan;
                    word_d  = '0;
                end
            end
            SEND: begin
                if (src_ready) begin
                    if (eop_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                        word_d  = '0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output registers are loaded with the beat that will be on the bus next cycle.
        show   = (state_d == SEND);
        base   = word_d * B_AW;
        last   = (base + B_AW) >= {1'b0, len_d};
        pos    = '0;
        data_d = '0;
        for (int i = 0; i < B; i++) begin
            pos = base + AW'(i);
            if (show && (pos < {1'b0, len_d})) begin
                data_d[DATA_W-1-8*i -: 8] = pos[7:0];
            end
        end
        sop_d      = show && (word_d == '0);
        eop_d      = show && last;
        empty_d    = (show && last) ? EMPTY_W'(base + B_AW - {1'b0, len_d}) : '0;
        chan_out_d = show ? chan_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            chan_q     <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            data_q     <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            empty_q    <= '0;
            chan_out_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            chan_q     <= chan_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            data_q     <= data_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            empty_q    <= empty_d;
            chan_out_q <= chan_out_d;
        end
    end

    assign busy        = (state_q == SEND);
    assign src_val     = busy;
    assign done        = done_q;
    assign pkt_cnt     = cnt_q;
    assign src_data    = data_q;
    assign src_sop     = sop_q;
    assign src_eop     = eop_q;
    assign src_empty   = empty_q;
    assign src_channel = chan_out_q;
    assign src_error   = 1'b0;
    assign src_tuser   = 1'b0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ast_pkt_gen.sv
// Directed + randomized bench for ast_pkt_gen; expected beats come from a
// byte-stream model that slices k mod 256 into B-byte words.
module tb_ast_pkt_gen;

  localparam int DATA_W    = 64;
  localparam int EMPTY_W   = 3;
  localparam int CHANNEL_W = 8;
  localparam int LEN_W     = 16;
  localparam int B         = DATA_W / 8;
  localparam int BW        = DATA_W + 2 + EMPTY_W;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [LEN_W-1:0]     pkt_len;
  logic [CHANNEL_W-1:0] pkt_chan;
  logic                 busy;
  logic                 done;
  logic [31:0]          pkt_cnt;
  logic [DATA_W-1:0]    src_data;
  logic                 src_sop;
  logic                 src_eop;
  logic                 src_val;
  logic [EMPTY_W-1:0]   src_empty;
  logic                 src_error;
  logic [CHANNEL_W-1:0] src_channel;
  logic                 src_tuser;
  logic                 src_ready;
  logic                 dbg_state;

  ast_pkt_gen #(
    .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .pkt_chan(pkt_chan),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .src_data(src_data),
    .src_sop(src_sop), .src_eop(src_eop), .src_val(src_val), .src_empty(src_empty),
    .src_error(src_error), .src_channel(src_channel), .src_tuser(src_tuser),
    .src_ready(src_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_cnt  = 32'd0;
  logic [BW-1:0] exp_q[$];
  int          ready_pat[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: packet as a byte stream, cut into B-byte beats
  task automatic model_push(input int len);
    int nw;
    int k;
    logic [DATA_W-1:0] d;
    logic [EMPTY_W-1:0] e;
    nw = (len + B - 1) / B;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int i = 0; i < B; i++) begin
        k = w * B + i;
        if (k < len) d[DATA_W-1-8*i -: 8] = 8'(k % 256);
      end
      e = (w == nw - 1) ? EMPTY_W'(nw * B - len) : EMPTY_W'(0);
      exp_q.push_back({d, 1'(w == 0), 1'(w == nw - 1), e});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_val"}, src_val, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, src_data, 0);
    check({tag, "_sop"}, src_sop, 0);
    check({tag, "_eop"}, src_eop, 0);
    check({tag, "_empty"}, src_empty, 0);
    check({tag, "_chan"}, src_channel, 0);
  endtask

  // mode: 0 = ready held high, 1 = random ready, 2 = ready from ready_pat
  // Returns in the done cycle so the caller may start the next packet at once.
  task automatic send_packet(input int len, input logic [CHANNEL_W-1:0] chan, input int mode,
                             input bit poke, input bit spot,
                             input logic [DATA_W-1:0] first_exp, input logic [DATA_W-1:0] last_exp);
    logic [BW-1:0] front;
    bit r;
    int cyc;
    int xfers;
    int nw;
    nw = (len + B - 1) / B;
    model_push(len);
    start = 1'b1;
    pkt_len = LEN_W'(len);
    pkt_chan = chan;
    tick();
    start = 1'b0;
    cyc = 0;
    xfers = 0;
    while (exp_q.size() > 0 && cyc < 20000) begin
      front = exp_q[0];
      check("val", src_val, 1);
      check("busy", busy, 1);
      check("data", src_data, front[BW-1 -: DATA_W]);
      check("sop", src_sop, front[EMPTY_W+1]);
      check("eop", src_eop, front[EMPTY_W]);
      check("empty", src_empty, front[EMPTY_W-1:0]);
      check("chan", src_channel, chan);
      check("err_tuser", {src_error, src_tuser}, 0);
      if (spot && front[EMPTY_W+1]) check("spot_first", src_data, first_exp);
      if (spot && front[EMPTY_W]) check("spot_last", src_data, last_exp);
      if (mode == 0) r = 1'b1;
      else if (mode == 2 && ready_pat.size() > 0) r = ready_pat.pop_front() != 0;
      else r = 1'($urandom_range(0, 1));
      src_ready = r;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        pkt_len = LEN_W'($urandom);
        pkt_chan = CHANNEL_W'($urandom);
      end
      tick();
      cyc++;
      if (r) begin
        void'(exp_q.pop_front());
        xfers++;
      end
    end
    start = 1'b0;
    src_ready = 1'b1;
    check("timeout_left", exp_q.size(), 0);
    exp_q.delete();
    check("xfers", xfers, nw);
    exp_cnt = exp_cnt + 32'd1;
    check("done_pulse", done, 1);
    check("pkt_cnt", pkt_cnt, exp_cnt);
    check_idle_outputs("post_eop");
  endtask

  task automatic idle_cycle();
    tick();
    check("done_clear", done, 0);
    check_idle_outputs("idle");
    check("pkt_cnt_hold", pkt_cnt, exp_cnt);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pkt_len = '0;
    pkt_chan = '0;
    src_ready = 1'b1;
    #2;
    check_idle_outputs("reset");
    check("reset_done", done, 0);
    check("reset_cnt", pkt_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // single beat, exact fit
    send_packet(8, 8'h5A, 0, 0, 1, 64'h0001020304050607, 64'h0001020304050607);
    idle_cycle();

    // two beats, partial last word
    send_packet(13, 8'h33, 0, 0, 1, 64'h0001020304050607, 64'h08090A0B0C000000);
    idle_cycle();

    // stalls in the middle of a 3-beat packet
    ready_pat = '{1, 0, 0, 1, 1};
    send_packet(24, 8'hC3, 2, 0, 0, '0, '0);
    idle_cycle();

    // zero length start is ignored
    start = 1'b1;
    pkt_len = '0;
    pkt_chan = 8'hFF;
    tick();
    start = 1'b0;
    check_idle_outputs("zero_len");
    check("zero_len_cnt", pkt_cnt, exp_cnt);
    check("zero_len_done", done, 0);
    tick();
    check_idle_outputs("zero_len2");

    // start pulses while busy must not disturb the packet
    send_packet(20, 8'h12, 1, 1, 0, '0, '0);
    idle_cycle();

    // back-to-back: second start in the done cycle
    send_packet(17, 8'h01, 0, 0, 0, '0, '0);
    send_packet(9, 8'h02, 1, 0, 0, '0, '0);
    idle_cycle();

    // randomized packets
    for (int n = 0; n < 12; n++) begin
      send_packet($urandom_range(1, 70), CHANNEL_W'($urandom), 1, 1'($urandom_range(0, 1)), 0, '0, '0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // largest length
    send_packet(65535, 8'h77, 0, 0, 0, '0, '0);
    idle_cycle();

    // reset during beat 1 of a 5-beat packet
    start = 1'b1;
    pkt_len = 16'd40;
    pkt_chan = 8'h11;
    tick();
    start = 1'b0;
    src_ready = 1'b1;
    check("pre_rst_sop", src_sop, 1);
    tick();
    check("pre_rst_val", src_val, 1);
    check("pre_rst_beat1", src_data, 64'h08090A0B0C0D0E0F);
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_cnt", pkt_cnt, 0);
    check("async_rst_done", done, 0);
    #1;
    rst = 1'b0;
    exp_cnt = 32'd0;
    tick();
    check_idle_outputs("post_rst");
    send_packet(3, 8'h44, 0, 0, 1, 64'h0001020000000000, 64'h0001020000000000);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ast_pkt_gen.md
AST_PKT_GEN -- requirements
Module: ast_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data bus width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter EMPTY_W, default 3, width of empty; SHALL equal log2(DATA_W/8).
REQ-003 SHALL have parameter CHANNEL_W, default 8, width of channel.
REQ-004 SHALL have parameter LEN_W, default 16, width of the packet length in bytes.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: port clk (input, 1) and port rst (input, 1).
REQ-006 SHALL have port start, input, 1, request to generate one packet.
REQ-007 SHALL have port pkt_len, input, LEN_W, packet length in bytes, sampled with start.
REQ-008 SHALL have port pkt_chan, input, CHANNEL_W, channel value, sampled with start.
REQ-009 SHALL have port busy, output, 1, high while a packet is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after the last beat is accepted.
REQ-011 SHALL have port pkt_cnt, output, 32, count of completed packets.
REQ-012 SHALL have Avalon-ST source outputs: src_data (DATA_W), src_sop (1), src_eop (1), src_val (1), src_empty (EMPTY_W), src_error (1), src_channel (CHANNEL_W) and src_tuser (1).
REQ-013 SHALL have port src_ready, input, 1, sink ready, with ready latency 0.

Function
REQ-014 SHALL implement FSM states IDLE and SEND; reset state IDLE.
REQ-015 In IDLE, start=1 with pkt_len!=0 SHALL capture pkt_len and pkt_chan and move to SEND on the next edge.
REQ-016 In IDLE, start=1 with pkt_len=0 SHALL be ignored; state, outputs and pkt_cnt SHALL be unchanged.
REQ-017 start while in SEND SHALL be ignored; captured length and channel SHALL NOT change mid-packet.
REQ-018 Latency: start accepted at edge N SHALL give src_val=1 and src_sop=1 in the cycle after edge N.
REQ-019 busy SHALL be 1 exactly when the state is SEND; src_val SHALL equal busy.
REQ-020 A beat SHALL transfer when src_val=1 and src_ready=1; the word index w SHALL advance only on a transfer.
REQ-021 While src_val=1 and src_ready=0, all src_* outputs SHALL hold stable.
REQ-022 Number of beats SHALL be W = ceil(len/B), where B = DATA_W/8.
REQ-023 src_sop SHALL be 1 only on beat 0; src_eop SHALL be 1 only on beat W-1; both SHALL be 1 when W=1.
REQ-024 Byte lane i (i=0 is the MSB byte, i.e. the first byte on the wire) of beat w SHALL be (w*B+i) mod 256.
REQ-025 Byte positions at or beyond len in the last beat SHALL be 0.
REQ-026 src_empty SHALL be W*B-len on the eop beat and 0 on all other beats.
REQ-027 src_channel SHALL equal the captured channel throughout the packet; src_error and src_tuser SHALL be constant 0.
REQ-028 Transfer of the eop beat SHALL return the FSM to IDLE; in the next cycle src_val=0 and done=1 for exactly one cycle.
REQ-029 pkt_cnt SHALL increment by 1 in the same edge that sets done, and SHALL wrap from 2^32-1 to 0.
REQ-030 start is accepted in the done cycle (busy=0) and SHALL give back-to-back packets with exactly one idle cycle between the eop and the next sop.
REQ-031 Word and byte arithmetic SHALL be LEN_W+1 bits wide so that len=2^LEN_W-1 does not overflow.
REQ-032 Outside SEND, src_data, src_sop, src_eop, src_empty and src_channel SHALL be 0.

Reset
REQ-033 rst=1 SHALL, asynchronously, force IDLE and set busy, done, src_val, src_sop, src_eop, src_data, src_empty, src_channel and pkt_cnt to 0.
REQ-034 rst asserted mid-packet SHALL drop src_val immediately with no eop; after release, the next start SHALL begin a fresh packet with sop.
REQ-035 The first start accepted after rst deassertion SHALL behave per REQ-018.

Verification
REQ-036 len=8, chan=0x5A, ready=1 -> one beat with sop=eop=1, data 0x0001020304050607, empty=0, channel 0x5A; done next cycle; pkt_cnt=1.
REQ-037 len=13, ready=1 -> beat0 0x0001020304050607, sop=1; beat1 0x08090A0B0C000000, eop=1, empty=3.
REQ-038 len=24 with ready toggling 1,0,0,1,1 -> exactly 3 transfers with data unchanged while stalled; the eop beat carries empty=0.
REQ-039 start with len=0, then start while busy -> no beats, pkt_cnt unchanged; captured len not overwritten.
REQ-040 rst pulse during beat 1 of a 5-beat packet -> src_val=0 immediately and pkt_cnt=0; the next start with len=3 gives a single beat 0x0001020000000000, empty=5.
REQ-041 Two starts back-to-back (the second in the done cycle) -> one idle cycle between the packets; an Avalon-ST protocol checker on the output never flags an error; pkt_cnt=2.
